// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_one_bit.sv
// One-bit full subtractor: D = A - B - Bin, with borrow out.
module one_bit_full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Bout,
  output logic D
);

  logic w_diff;

  always_comb begin
    w_diff = A ^ B;
    D      = w_diff ^ Bin;
    Bout   = (~A & B) | (Bin & ~w_diff);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, with start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             Bout,
  output logic             V
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  sub_state_e       r_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_res;
  logic [CntW-1:0]  r_count;
  logic             r_borrow;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_z;
  logic             r_bout;
  logic             r_v;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_next;

  one_bit_full_subtractor u_cell (
    .A    (r_sh_a[0]),
    .B    (r_sh_b[0]),
    .Bin  (r_borrow),
    .Bout (w_bo),
    .D    (w_d)
  );

  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_res    <= '0;
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_z      <= '0;
      r_bout   <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_sh_a   <= A;
            r_sh_b   <= B;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_sign_a <= A[WIDTH-1];
            r_sign_b <= B[WIDTH-1];
            r_busy   <= 1'b1;
            r_state  <= StRun;
          end
        end
        StRun: begin
          r_sh_a   <= r_sh_a >> 1;
          r_sh_b   <= r_sh_b >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bo;
          r_count  <= r_count + 1'b1;
          if (r_count == LastCnt) begin
            // w_d is the final MSB of the difference on this edge.
            r_z     <= w_res_next;
            r_bout  <= w_bo;
            r_v     <= (r_sign_a ^ r_sign_b) & (r_sign_a ^ w_d);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Z    = r_z;
  assign Bout = r_bout;
  assign V    = r_v;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus random operands.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Z;
  logic         Bout;
  logic         V;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] prev_z;
  logic         prev_bout;
  logic         prev_v;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Z     (Z),
    .Bout  (Bout),
    .V     (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] z, output logic bo, output logic v);
    int ua;
    int ub;
    int sa;
    int sb;
    int sd;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sd = sa - sb;
    z  = W'((ua - ub + (1 << W)) % (1 << W));
    bo = (ua < ub);
    v  = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
  endtask

  // One operation; hold keeps start high throughout, pulse raises start during RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit pulse);
    logic [W-1:0] ez;
    logic         eb;
    logic         ev;
    model(a, b, ez, eb, ev);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= W; k++) begin
      if (pulse && k == 3) begin
        start = 1'b1;
        A = ~a;
        B = a;
      end else if (!hold) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k < W) begin
        chk("busy_run", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("z_held", 32'(Z), 32'(prev_z));
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("z", 32'(Z), 32'(ez));
        chk("bout", 32'(Bout), 32'(eb));
        chk("v", 32'(V), 32'(ev));
      end
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("z_hold_idle", 32'(Z), 32'(ez));
    prev_z    = ez;
    prev_bout = eb;
    prev_v    = ev;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    prev_z = '0;
    prev_bout = 1'b0;
    prev_v = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", 32'(Z), 32'd0);
    chk("rst_bout", 32'(Bout), 32'd0);
    chk("rst_v", 32'(V), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0);

    // Abort mid-operation; outputs must clear without a clock edge.
    @(negedge clk);
    A = 8'h05;
    B = 8'h03;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_z", 32'(Z), 32'd0);
    chk("abort_bout", 32'(Bout), 32'd0);
    chk("abort_v", 32'(V), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_z = '0;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_busy", 32'(busy), 32'd0);
    end

    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'h5A, 8'h13, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);

    // start during RUN must be ignored.
    run_op(8'h40, 8'hC0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("pulse_not_queued", 32'(busy), 32'd0);

    // Back-to-back with start held: each accept lands exactly WIDTH+2 cycles later.
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b1, 1'b0);
    end
    start = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes Z = A - B one bit per clock, LSB first.
- Built from a single one-bit full-subtractor cell and a registered borrow, the inverse operation of the team's ripple adder.
- Sits in the datapath wherever area matters more than latency. Uses a start/busy/done handshake towards the controller.
- Reports the unsigned borrow and the signed overflow alongside the difference.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; Z, Bout and V are valid from this cycle on.
- Z  output  WIDTH  difference A - B, modulo 2^WIDTH.
- Bout  output  1  unsigned borrow out: 1 iff A < B unsigned.
- V  output  1  signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, Z = 0, Bout = 0, V = 0.
  - Internal shift registers, borrow register and bit counter all cleared.
- Reset asserted mid-operation aborts immediately; the partial result is discarded.
- States: IDLE, RUN, DONE (encoding is in the shared header).
- IDLE:
  - Accepting edge is a rising clk with start = 1.
  - On that edge: load shA <= A, shB <= B, borrow <= 0, count <= 0, and latch the sign bits A[WIDTH-1], B[WIDTH-1]; go to RUN.
  - With start = 0: stay in IDLE, outputs unchanged.
- RUN (busy = 1):
  - Each cycle the cell computes d = shA[0] ^ shB[0] ^ borrow.
  - Borrow out of the cell: bo = (~shA[0] & shB[0]) | (borrow & ~(shA[0] ^ shB[0])).
  - On the edge:
    - shA and shB shift right one bit.
    - The result shift register shifts right with d entering at the MSB.
    - borrow <= bo.
    - count <= count + 1.
  - When count == WIDTH-1 the edge also goes to DONE.
  - Z, Bout and V are driven from their registers; they are not updated bit by bit on the outputs during RUN.
- Transition into DONE (same edge):
  - Z <= final result register.
  - Bout <= final bo.
  - V <= (signA ^ signB) & (signA ^ Z[WIDTH-1]), using the final MSB.
- DONE:
  - done = 1 for exactly this one cycle; busy = 0.
  - Unconditionally returns to IDLE on the next edge.
- Latency: start sampled at edge N gives done high in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles from acceptance. Next start can be accepted at edge N+WIDTH+2.
- start high in RUN or DONE is ignored and not queued. It must be held or re-asserted in IDLE to be taken.
- A and B may change freely after the accepting edge.
- Z, Bout and V hold their last values until the next DONE transition or reset.
- start held high continuously gives back-to-back operations every WIDTH+2 cycles.
- count width is clog2(WIDTH) bits. No wrap-around is reachable because of the exit at WIDTH-1.

Decomposition:
- Shared header: state encodings for IDLE/RUN/DONE.
- Sub-module one_bit_full_subtractor:
  - Ports A, B, Bin, Bout, D.
  - Purely combinational.
  - Instantiated once for the serial datapath.
- Remaining logic (FSM, shift registers, counter, flags) stays in serial_subtractor.

Test Plan:
- Reset mid-operation: A=0x05, B=0x03, start, then rst_n low for 1 cycle at cycle 4 → all outputs 0 asynchronously, state IDLE, no done pulse afterwards.
- WIDTH=8, A=0x05, B=0x03, one-cycle start → busy for 8 cycles, done one cycle later, Z=0x02, Bout=0, V=0.
- A=0x03, B=0x05 → Z=0xFE, Bout=1, V=0.
- A=0x80, B=0x01 → Z=0x7F, Bout=0, V=1 (negative minus positive overflow); then A=0x7F, B=0xFF → Z=0x80, Bout=1, V=1.
- A=0x00, B=0x00 → Z=0x00, Bout=0, V=0. Then A=0xFF, B=0xFF → Z=0x00, Bout=0, V=0, and the previous Z is held until this done.
- start pulsed at cycle 3 of RUN with different operands → ignored, first result unchanged. Separately, start held high → done every 10 cycles, each result matching the operands present at its accepting edge.
